qpmm_issue_sched: RTL and testbench

- Round-robin scheduler that shares one fully pipelined, non-stallable Montgomery multiplier (QPMM core, fixed A/B-to-Z latency) among NREQ requesters.
- Accepts at most one operand pair per cycle and tracks ownership and user tag of every in-flight operation in a LAT-deep shadow pipeline.
- Routes each result back to its originating requester.
- Bounds outstanding operations per requester so a single client cannot monopolise the pipeline.

---
 rtl/qpmm_issue_sched.sv | 147 ++++++++++++++
 tb/tb_qpmm_issue_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpmm_issue_sched.sv
// Round-robin issue scheduler that shares one fixed-latency pipelined Montgomery multiplier
// among NREQ requesters, tracking owner/tag of every in-flight operation in a shadow pipeline.
module qpmm_issue_sched #(
    parameter int NREQ    = 3,
    parameter int W       = 256,
    parameter int LAT     = 44,
    parameter int MAX_OUT = 8,
    parameter int TAGW    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    input  logic                 halt,
    output logic [W-1:0]         mm_a,
    output logic [W-1:0]         mm_b,
    input  logic [W-1:0]         mm_z,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [W-1:0]         rsp_z,
    output logic [TAGW-1:0]      rsp_tag,
    output logic                 busy
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]   OUT_LIMIT = CW'(MAX_OUT);
    localparam logic [OW-1:0]   LAST_IDX  = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    logic [OW-1:0]   ptr_reg;
    logic [CW-1:0]   out_cnt_reg [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   grant_idx;
    logic [OW-1:0]   cand_idx;
    logic            fire;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [TAGW-1:0] sel_tag;

    // Stage 0 is the issue stage (aligned with mm_a/mm_b); stage LAT is aligned with mm_z.
    logic [LAT:0]    sh_valid_reg;
    logic [OW-1:0]   sh_owner_reg [LAT+1];
    logic [TAGW-1:0] sh_tag_reg   [LAT+1];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign eligible[gi] = req_valid[gi] && (out_cnt_reg[gi] < OUT_LIMIT) && !halt;

            // A fire and a returning result in the same cycle cancel out.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_cnt_reg[gi] <= '0;
                end else if (grant[gi] && !rsp_valid[gi]) begin
                    out_cnt_reg[gi] <= out_cnt_reg[gi] + CW'(1);
                end else if (!grant[gi] && rsp_valid[gi]) begin
                    out_cnt_reg[gi] <= out_cnt_reg[gi] - CW'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand_idx  = '0;
        fire      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = OW'((int'(ptr_reg) + k) % NREQ);
            if (!fire && eligible[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                fire            = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_a     = req_a[grant_idx*W +: W];
    assign sel_b     = req_b[grant_idx*W +: W];
    assign sel_tag   = req_tag[grant_idx*TAGW +: TAGW];

    // Operands are zeroed on idle cycles so the multiplier never sees stale data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm_a    <= '0;
            mm_b    <= '0;
            ptr_reg <= '0;
        end else if (fire) begin
            mm_a    <= sel_a;
            mm_b    <= sel_b;
            ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + OW'(1);
        end else begin
            mm_a    <= '0;
            mm_b    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_valid_reg[0] <= 1'b0;
            sh_owner_reg[0] <= '0;
            sh_tag_reg[0]   <= '0;
        end else begin
            sh_valid_reg[0] <= fire;
            sh_owner_reg[0] <= grant_idx;
            sh_tag_reg[0]   <= sel_tag;
        end
    end

    generate
        for (genvar gi = 1; gi <= LAT; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sh_valid_reg[gi] <= 1'b0;
                    sh_owner_reg[gi] <= '0;
                    sh_tag_reg[gi]   <= '0;
                end else begin
                    sh_valid_reg[gi] <= sh_valid_reg[gi-1];
                    sh_owner_reg[gi] <= sh_owner_reg[gi-1];
                    sh_tag_reg[gi]   <= sh_tag_reg[gi-1];
                end
            end
        end
    endgenerate

    // Result data holds its last value between strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_z     <= '0;
            rsp_tag   <= '0;
        end else begin
            rsp_valid <= sh_valid_reg[LAT] ? (ONE_HOT0 << sh_owner_reg[LAT]) : '0;
            if (sh_valid_reg[LAT]) begin
                rsp_z   <= mm_z;
                rsp_tag <= sh_tag_reg[LAT];
            end
        end
    end

    assign busy = (|sh_valid_reg) || (|rsp_valid);

endmodule

// File: tb/tb_qpmm_issue_sched.sv
// Bench for qpmm_issue_sched: directed table and sequences plus randomized traffic checked
// against a cycle-level reference model of the scheduling rules.
module tb_qpmm_issue_sched;

    localparam int NREQ    = 3;
    localparam int W       = 256;
    localparam int LAT     = 44;
    localparam int MAX_OUT = 8;
    localparam int TAGW    = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 halt;
    logic [W-1:0]         mm_a;
    logic [W-1:0]         mm_b;
    logic [W-1:0]         mm_z;
    logic [NREQ-1:0]      rsp_valid;
    logic [W-1:0]         rsp_z;
    logic [TAGW-1:0]      rsp_tag;
    logic                 busy;

    always #5 clk = ~clk;

    qpmm_issue_sched #(
        .NREQ(NREQ), .W(W), .LAT(LAT), .MAX_OUT(MAX_OUT), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .halt(halt),
        .mm_a(mm_a), .mm_b(mm_b), .mm_z(mm_z), .rsp_valid(rsp_valid),
        .rsp_z(rsp_z), .rsp_tag(rsp_tag), .busy(busy)
    );

    // Multiplier model: product delayed LAT cycles, not reset.
    logic [W-1:0] mul_dly [LAT];
    always @(posedge clk) begin
        mul_dly[0] <= mm_a * mm_b;
        for (int j = 1; j < LAT; j++) mul_dly[j] <= mul_dly[j-1];
    end
    assign mm_z = mul_dly[LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < W; j += 32) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int              due;
        int              owner;
        logic [TAGW-1:0] tag;
        logic [W-1:0]    z;
    } pend_t;

    pend_t           pend[$];
    pend_t           item;
    bit              model_on = 0;
    int              m_cyc = 0;
    int              m_out [NREQ];
    int              m_ptr;
    int              m_g;
    int              m_cand;
    bit              m_deliver;
    logic [W-1:0]    m_a, m_b, m_z, m_pa, m_pb;
    logic [TAGW-1:0] m_tag;
    logic [NREQ-1:0] m_rv, m_rdy;

    task model_step();
        if (!rstn) begin
            pend.delete();
            for (int i = 0; i < NREQ; i++) m_out[i] = 0;
            m_ptr = 0; m_a = '0; m_b = '0; m_z = '0; m_tag = '0;
            chk("rst_rsp_valid", W'(rsp_valid), '0);
            chk("rst_busy", W'(busy), '0);
            chk("rst_mm_a", mm_a, '0);
        end else begin
            m_deliver = 0;
            m_rv = '0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_deliver = 1;
                m_rv[pend[0].owner] = 1'b1;
                m_z   = pend[0].z;
                m_tag = pend[0].tag;
            end
            chk("m_busy", W'(busy), W'(pend.size() > 0));
            chk("m_rsp_valid", W'(rsp_valid), W'(m_rv));
            chk("m_rsp_z", rsp_z, m_z);
            chk("m_rsp_tag", W'(rsp_tag), W'(m_tag));
            chk("m_mm_a", mm_a, m_a);
            chk("m_mm_b", mm_b, m_b);
            m_g = -1;
            for (int k = 0; k < NREQ; k++) begin
                m_cand = (m_ptr + k) % NREQ;
                if (m_g < 0 && req_valid[m_cand] && m_out[m_cand] < MAX_OUT && !halt) m_g = m_cand;
            end
            m_rdy = '0;
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            chk("m_req_ready", W'(req_ready), W'(m_rdy));
            if (m_deliver) begin
                $display("rsp cyc=%0d req=%0d tag=%0h z=%0h", m_cyc, pend[0].owner, pend[0].tag, pend[0].z);
                m_out[pend[0].owner]--;
                void'(pend.pop_front());
            end
            if (m_g >= 0) begin
                m_out[m_g]++;
                m_ptr = (m_g + 1) % NREQ;
                m_pa = req_a[m_g*W +: W];
                m_pb = req_b[m_g*W +: W];
                item.due   = m_cyc + LAT + 2;
                item.owner = m_g;
                item.tag   = req_tag[m_g*TAGW +: TAGW];
                item.z     = m_pa * m_pb;
                pend.push_back(item);
                m_a = m_pa;
                m_b = m_pb;
            end else begin
                m_a = '0;
                m_b = '0;
            end
        end
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task next_cycle();
        @(posedge clk);
        #1;
    endtask

    task reset_dut();
        next_cycle();
        rstn = 1'b0;
        req_valid = '0;
        halt = 1'b0;
        next_cycle();
        rstn = 1'b1;
    endtask

    task wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
        next_cycle();
    endtask

    task rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W]       = rnd_w();
            req_b[i*W +: W]       = rnd_w();
            req_tag[i*TAGW +: TAGW] = TAGW'($urandom);
        end
    endtask

    typedef struct {
        int              req;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [TAGW-1:0] tag;
        logic [NREQ-1:0] rdy;
        logic [W-1:0]    z;
    } vec_t;

    vec_t         vecs [4];
    logic [W-1:0] ones;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; req_valid = '0; halt = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0;
        ones = '1;
        vecs[0] = '{0, W'(3), W'(5), 4'd7, 3'b001, W'(15)};
        vecs[1] = '{2, W'(1000), W'(1000), 4'd15, 3'b100, W'(1000000)};
        vecs[2] = '{1, ones, W'(2), 4'd0, 3'b010, ones - W'(1)};
        vecs[3] = '{1, W'(1) << (W - 1), W'(2), 4'd9, 3'b010, W'(0)};
        model_on = 1;

        // Single isolated requests: latency, data, tag, busy window, hold.
        for (int v = 0; v < 4; v++) begin
            reset_dut();
            for (int k = 0; k <= 47; k++) begin
                rnd_ops();
                if (k == 0) begin
                    req_valid = NREQ'(1) << vecs[v].req;
                    req_a[vecs[v].req*W +: W] = vecs[v].a;
                    req_b[vecs[v].req*W +: W] = vecs[v].b;
                    req_tag[vecs[v].req*TAGW +: TAGW] = vecs[v].tag;
                end else begin
                    req_valid = '0;
                end
                @(negedge clk);
                if (k == 0) chk("t1_ready", W'(req_ready), W'(vecs[v].rdy));
                if (k == 1) begin
                    chk("t1_mm_a", mm_a, vecs[v].a);
                    chk("t1_mm_b", mm_b, vecs[v].b);
                    chk("t1_busy_start", W'(busy), W'(1));
                end
                if (k == 45) chk("t1_rsp_early", W'(rsp_valid), '0);
                if (k == 46) begin
                    chk("t1_rsp_valid", W'(rsp_valid), W'(vecs[v].rdy));
                    chk("t1_rsp_z", rsp_z, vecs[v].z);
                    chk("t1_rsp_tag", W'(rsp_tag), W'(vecs[v].tag));
                    chk("t1_busy_end", W'(busy), W'(1));
                end
                if (k == 47) begin
                    chk("t1_busy_low", W'(busy), '0);
                    chk("t1_rsp_off", W'(rsp_valid), '0);
                    chk("t1_rsp_z_hold", rsp_z, vecs[v].z);
                end
                next_cycle();
            end
        end

        // Fairness: all requesters valid, grants rotate, responses in issue order.
        reset_dut();
        for (int k = 0; k <= 60; k++) begin
            rnd_ops();
            req_valid = (k < 12) ? '1 : '0;
            for (int i = 0; i < NREQ; i++) req_tag[i*TAGW +: TAGW] = TAGW'(k / 3);
            @(negedge clk);
            if (k < 12) chk("t2_grant", W'(req_ready), W'(NREQ'(1) << (k % 3)));
            if (k >= 46 && k < 58) begin
                chk("t2_rsp_valid", W'(rsp_valid), W'(NREQ'(1) << ((k - 46) % 3)));
                chk("t2_rsp_tag", W'(rsp_tag), W'((k - 46) / 3));
            end
            if (k == 58) chk("t2_rsp_done", W'(rsp_valid), '0);
            next_cycle();
        end

        // Outstanding limit on requester 1.
        reset_dut();
        for (int k = 0; k < 100; k++) begin
            rnd_ops();
            req_valid = 3'b010;
            @(negedge clk);
            if (k <= 7) chk("t3_ready_on", W'(req_ready), W'(3'b010));
            if (k >= 8 && k <= 46) chk("t3_ready_limit", W'(req_ready), '0);
            if (k == 47) chk("t3_ready_resume", W'(req_ready), W'(3'b010));
            next_cycle();
        end
        req_valid = '0;
        wait_idle();

        // Simultaneous fire and response on requester 2 at the limit.
        reset_dut();
        for (int k = 0; k < 110; k++) begin
            rnd_ops();
            req_valid = 3'b100;
            @(negedge clk);
            if (k == 46) chk("t4_ready_full", W'(req_ready), '0);
            if (k == 47 || k == 48) chk("t4_ready_swap", W'(req_ready), W'(3'b100));
            next_cycle();
        end
        req_valid = '0;
        wait_idle();

        // Halt: grants stop, pipeline drains, grant resumes from ptr=2.
        reset_dut();
        for (int k = 0; k <= 52; k++) begin
            rnd_ops();
            req_valid = '1;
            halt = (k >= 5 && k < 52);
            @(negedge clk);
            if (k < 5) chk("t5_grant", W'(req_ready), W'(NREQ'(1) << (k % 3)));
            if (k >= 5 && k < 52) chk("t5_halted", W'(req_ready), '0);
            if (k >= 46 && k <= 50) chk("t5_rsp", W'(rsp_valid), W'(NREQ'(1) << ((k - 46) % 3)));
            if (k == 50) chk("t5_busy_hi", W'(busy), W'(1));
            if (k == 51) chk("t5_busy_lo", W'(busy), '0);
            if (k == 52) chk("t5_resume", W'(req_ready), W'(3'b100));
            next_cycle();
        end
        req_valid = '0;
        halt = 1'b0;
        wait_idle();

        // Reset mid-stream: immediate clear, no stale responses, fresh latency.
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            rnd_ops();
            req_valid = '1;
            next_cycle();
        end
        rstn = 1'b0;
        req_valid = '0;
        #1;
        chk("t6_async_mm_a", mm_a, '0);
        chk("t6_async_mm_b", mm_b, '0);
        chk("t6_async_rsp_valid", W'(rsp_valid), '0);
        chk("t6_async_rsp_z", rsp_z, '0);
        chk("t6_async_rsp_tag", W'(rsp_tag), '0);
        chk("t6_async_busy", W'(busy), '0);
        next_cycle();
        rstn = 1'b1;
        for (int k = 11; k <= 108; k++) begin
            rnd_ops();
            req_valid = (k == 61) ? 3'b001 : 3'b000;
            if (k == 61) begin
                req_a[0 +: W] = W'(6);
                req_b[0 +: W] = W'(7);
                req_tag[0 +: TAGW] = 4'd3;
            end
            @(negedge clk);
            if (k <= 60) chk("t6_no_stale_rsp", W'(rsp_valid), '0);
            if (k == 106) chk("t6_rsp_early", W'(rsp_valid), '0);
            if (k == 107) begin
                chk("t6_rsp_valid", W'(rsp_valid), W'(3'b001));
                chk("t6_rsp_z", rsp_z, W'(42));
                chk("t6_rsp_tag", W'(rsp_tag), W'(3));
            end
            next_cycle();
        end

        // Randomized traffic with random halt and one mid-run reset.
        reset_dut();
        for (int k = 0; k < 700; k++) begin
            rnd_ops();
            for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom % 10) < 7;
            halt = ($urandom % 12) == 0;
            if (k == 350) rstn = 1'b0;
            if (k == 351) rstn = 1'b1;
            next_cycle();
        end
        req_valid = '0;
        halt = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
